// File: rtl/edge_setup_pkg.sv
// Shared raster timing constants, FSM encoding and edge vertex tables for edge_setup.
package edge_setup_pkg;

  localparam logic [9:0] H_LAST          = 10'd799;
  localparam logic [9:0] V_ACTIVE        = 10'd480;
  localparam logic [9:0] READY_LAST_LINE = 10'd522;
  localparam logic [9:0] COMMIT_LINE     = 10'd523;
  localparam logic [9:0] V_LAST          = 10'd524;
  localparam logic [3:0] CALC_LAST       = 4'd11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic signed [19:0] int20_t;
  typedef logic signed [21:0] q2_20_t;

  // Edges 0..2 belong to triangle (v0,v1,v2), edges 3..5 to triangle (v0,v2,v3).
  function automatic logic [1:0] edge_vi(input logic [2:0] e);
    case (e)
      3'd0:    return 2'd0;
      3'd1:    return 2'd1;
      3'd2:    return 2'd2;
      3'd3:    return 2'd0;
      3'd4:    return 2'd2;
      3'd5:    return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] edge_vj(input logic [2:0] e);
    case (e)
      3'd0:    return 2'd1;
      3'd1:    return 2'd2;
      3'd2:    return 2'd0;
      3'd3:    return 2'd2;
      3'd4:    return 2'd3;
      3'd5:    return 2'd0;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/edge_mul.sv
// Shared setup multiplier: operands registered on load, product is the low 20 bits.
module edge_mul
  import edge_setup_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic signed [19:0] a,
  input  logic signed [19:0] b,
  output logic signed [19:0] p
);

  int20_t a_r;
  int20_t b_r;

  // Operand registers, updated only while setup is stepping through products
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r <= 20'sd0;
      b_r <= 20'sd0;
    end else if (load) begin
      a_r <= a;
      b_r <= b;
    end else begin
      a_r <= a_r;
      b_r <= b_r;
    end
  end

  assign p = a_r * b_r;

endmodule

// File: rtl/edge_setup.sv
// Per-frame triangle setup and per-line edge/barycentric stepper ahead of the rasterizer.
// Macro EDGE_SETUP_BARY_EN builds the barycentric path; without it bar_* outputs are tied to 0.
module edge_setup
  import edge_setup_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [9:0]         x,
  input  logic [9:0]         y,
  input  logic               frame_valid,
  output logic               frame_ready,
  input  logic signed [19:0] x_v0,
  input  logic signed [19:0] x_v1,
  input  logic signed [19:0] x_v2,
  input  logic signed [19:0] x_v3,
  input  logic signed [19:0] y_v0,
  input  logic signed [19:0] y_v1,
  input  logic signed [19:0] y_v2,
  input  logic signed [19:0] y_v3,
  input  logic [2:0]         tri_color_in,
  input  logic signed [21:0] bar_iy_in,
  input  logic signed [21:0] bar_iz_in,
  input  logic signed [21:0] bar2_iy_in,
  input  logic signed [21:0] bar2_iz_in,
  input  logic signed [21:0] bar_iy_dy_in,
  input  logic signed [21:0] bar_iz_dy_in,
  input  logic signed [21:0] bar2_iy_dy_in,
  input  logic signed [21:0] bar2_iz_dy_in,
  input  logic signed [21:0] bar_iy_dx_in,
  input  logic signed [21:0] bar_iz_dx_in,
  input  logic signed [21:0] bar2_iy_dx_in,
  input  logic signed [21:0] bar2_iz_dx_in,
  output logic signed [19:0] y_screen_v0,
  output logic signed [19:0] y_screen_v1,
  output logic signed [19:0] y_screen_v2,
  output logic signed [19:0] y_screen_v3,
  output logic [2:0]         tri_color,
  output logic signed [19:0] e0_init_t1,
  output logic signed [19:0] e1_init_t1,
  output logic signed [19:0] e2_init_t1,
  output logic signed [19:0] e0_init_t2,
  output logic signed [19:0] e1_init_t2,
  output logic signed [19:0] e2_init_t2,
  output logic signed [21:0] bar_iy,
  output logic signed [21:0] bar_iz,
  output logic signed [21:0] bar2_iy,
  output logic signed [21:0] bar2_iz,
  output logic signed [21:0] bar_iy_dx,
  output logic signed [21:0] bar_iz_dx,
  output logic signed [21:0] bar2_iy_dx,
  output logic signed [21:0] bar2_iz_dx
);

  state_t     state_r;
  logic [3:0] step_r;
  logic       mul_vld_r;
  logic [3:0] mul_idx_r;
  logic       shadow_pending_r;
  int20_t     sh_x_r [4];
  int20_t     sh_y_r [4];
  logic [2:0] sh_color_r;
  int20_t     sh_e_r [6];
  int20_t     base_x_r [4];
  int20_t     base_y_r [4];
  logic [2:0] base_color_r;
  int20_t     base_e_r [6];
  int20_t     cur_e_r [6];

  int20_t     vin_x_s [4];
  int20_t     vin_y_s [4];
  logic [1:0] vi_s;
  logic [1:0] vj_s;
  int20_t     op_a_s;
  int20_t     op_b_s;
  int20_t     mul_p_s;
  int20_t     step_e_s [6];
  logic       accept_s;
  logic       commit_s;
  logic       advance_s;

  // Vertex input ports gathered for indexed capture
  always_comb begin
    vin_x_s[0] = x_v0;
    vin_x_s[1] = x_v1;
    vin_x_s[2] = x_v2;
    vin_x_s[3] = x_v3;
    vin_y_s[0] = y_v0;
    vin_y_s[1] = y_v1;
    vin_y_s[2] = y_v2;
    vin_y_s[3] = y_v3;
  end

  assign frame_ready = rst_n & (state_r == IDLE) & (y >= V_ACTIVE) & (y <= READY_LAST_LINE);
  assign accept_s    = frame_valid & frame_ready;
  assign commit_s    = (y == COMMIT_LINE) & (x == H_LAST);
  assign advance_s   = (x == H_LAST) & ((y < V_ACTIVE) | (y == V_LAST));

  // Operand select: even steps form (xj-xi)*yi, odd steps form (yj-yi)*xi
  always_comb begin
    vi_s   = edge_vi(step_r[3:1]);
    vj_s   = edge_vj(step_r[3:1]);
    op_a_s = 20'sd0;
    op_b_s = 20'sd0;
    if (!step_r[0]) begin
      op_a_s = sh_x_r[vj_s] - sh_x_r[vi_s];
      op_b_s = sh_y_r[vi_s];
    end else begin
      op_a_s = sh_y_r[vj_s] - sh_y_r[vi_s];
      op_b_s = sh_x_r[vi_s];
    end
  end

  // Per-line edge increment from the committed vertices
  always_comb begin
    for (int k = 0; k < 6; k++) begin
      step_e_s[k] = base_x_r[edge_vi(3'(k))] - base_x_r[edge_vj(3'(k))];
    end
  end

  edge_mul u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (state_r == CALC),
    .a     (op_a_s),
    .b     (op_b_s),
    .p     (mul_p_s)
  );

  // Setup FSM: capture, twelve multiply steps, accumulate into the shadow set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r          <= IDLE;
      step_r           <= 4'd0;
      mul_vld_r        <= 1'b0;
      mul_idx_r        <= 4'd0;
      shadow_pending_r <= 1'b0;
      sh_color_r       <= 3'd0;
      for (int k = 0; k < 4; k++) begin
        sh_x_r[k] <= 20'sd0;
        sh_y_r[k] <= 20'sd0;
      end
      for (int k = 0; k < 6; k++) begin
        sh_e_r[k] <= 20'sd0;
      end
    end else begin
      mul_vld_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            for (int k = 0; k < 4; k++) begin
              sh_x_r[k] <= vin_x_s[k];
              sh_y_r[k] <= vin_y_s[k];
            end
            for (int k = 0; k < 6; k++) begin
              sh_e_r[k] <= 20'sd0;
            end
            sh_color_r <= tri_color_in;
            step_r     <= 4'd0;
            state_r    <= CALC;
          end
        end
        CALC: begin
          mul_vld_r <= 1'b1;
          mul_idx_r <= step_r;
          if (step_r == CALC_LAST) begin
            state_r <= DONE;
          end else begin
            step_r <= step_r + 4'd1;
          end
        end
        DONE: begin
          shadow_pending_r <= 1'b1;
          state_r          <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
      // The product of the previous step lands one cycle after its operands were loaded
      if (mul_vld_r) begin
        for (int k = 0; k < 6; k++) begin
          if (mul_idx_r[3:1] == 3'(k)) begin
            if (mul_idx_r[0]) begin
              sh_e_r[k] <= sh_e_r[k] - mul_p_s;
            end else begin
              sh_e_r[k] <= sh_e_r[k] + mul_p_s;
            end
          end
        end
      end
      if (commit_s && shadow_pending_r) begin
        shadow_pending_r <= 1'b0;
      end
    end
  end

  // Frame-boundary commit of the shadow set and per-line edge stepping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_color_r <= 3'd0;
      for (int k = 0; k < 4; k++) begin
        base_x_r[k] <= 20'sd0;
        base_y_r[k] <= 20'sd0;
      end
      for (int k = 0; k < 6; k++) begin
        base_e_r[k] <= 20'sd0;
        cur_e_r[k]  <= 20'sd0;
      end
    end else if (commit_s) begin
      if (shadow_pending_r) begin
        base_color_r <= sh_color_r;
        for (int k = 0; k < 4; k++) begin
          base_x_r[k] <= sh_x_r[k];
          base_y_r[k] <= sh_y_r[k];
        end
        for (int k = 0; k < 6; k++) begin
          base_e_r[k] <= sh_e_r[k];
          cur_e_r[k]  <= sh_e_r[k];
        end
      end else begin
        for (int k = 0; k < 6; k++) begin
          cur_e_r[k] <= base_e_r[k];
        end
      end
    end else if (advance_s) begin
      for (int k = 0; k < 6; k++) begin
        cur_e_r[k] <= cur_e_r[k] + step_e_s[k];
      end
    end
  end

  assign y_screen_v0 = base_y_r[0];
  assign y_screen_v1 = base_y_r[1];
  assign y_screen_v2 = base_y_r[2];
  assign y_screen_v3 = base_y_r[3];
  assign tri_color   = base_color_r;
  assign e0_init_t1  = cur_e_r[0];
  assign e1_init_t1  = cur_e_r[1];
  assign e2_init_t1  = cur_e_r[2];
  assign e0_init_t2  = cur_e_r[3];
  assign e1_init_t2  = cur_e_r[4];
  assign e2_init_t2  = cur_e_r[5];

`ifdef EDGE_SETUP_BARY_EN
  q2_20_t bin_s [4];
  q2_20_t bdy_in_s [4];
  q2_20_t bdx_in_s [4];
  q2_20_t sh_bi_r [4];
  q2_20_t sh_bdy_r [4];
  q2_20_t sh_bdx_r [4];
  q2_20_t base_bi_r [4];
  q2_20_t base_bdy_r [4];
  q2_20_t bdx_r [4];
  q2_20_t cur_bi_r [4];

  // Barycentric input ports gathered for indexed capture
  always_comb begin
    bin_s[0]    = bar_iy_in;
    bin_s[1]    = bar_iz_in;
    bin_s[2]    = bar2_iy_in;
    bin_s[3]    = bar2_iz_in;
    bdy_in_s[0] = bar_iy_dy_in;
    bdy_in_s[1] = bar_iz_dy_in;
    bdy_in_s[2] = bar2_iy_dy_in;
    bdy_in_s[3] = bar2_iz_dy_in;
    bdx_in_s[0] = bar_iy_dx_in;
    bdx_in_s[1] = bar_iz_dx_in;
    bdx_in_s[2] = bar2_iy_dx_in;
    bdx_in_s[3] = bar2_iz_dx_in;
  end

  // Barycentric shadow capture on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        sh_bi_r[k]  <= 22'sd0;
        sh_bdy_r[k] <= 22'sd0;
        sh_bdx_r[k] <= 22'sd0;
      end
    end else if (accept_s) begin
      for (int k = 0; k < 4; k++) begin
        sh_bi_r[k]  <= bin_s[k];
        sh_bdy_r[k] <= bdy_in_s[k];
        sh_bdx_r[k] <= bdx_in_s[k];
      end
    end
  end

  // Barycentric commit and per-line stepping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        base_bi_r[k]  <= 22'sd0;
        base_bdy_r[k] <= 22'sd0;
        bdx_r[k]      <= 22'sd0;
        cur_bi_r[k]   <= 22'sd0;
      end
    end else if (commit_s) begin
      for (int k = 0; k < 4; k++) begin
        if (shadow_pending_r) begin
          base_bi_r[k]  <= sh_bi_r[k];
          base_bdy_r[k] <= sh_bdy_r[k];
          bdx_r[k]      <= sh_bdx_r[k];
          cur_bi_r[k]   <= sh_bi_r[k];
        end else begin
          cur_bi_r[k] <= base_bi_r[k];
        end
      end
    end else if (advance_s) begin
      for (int k = 0; k < 4; k++) begin
        cur_bi_r[k] <= cur_bi_r[k] + base_bdy_r[k];
      end
    end
  end

  assign bar_iy     = cur_bi_r[0];
  assign bar_iz     = cur_bi_r[1];
  assign bar2_iy    = cur_bi_r[2];
  assign bar2_iz    = cur_bi_r[3];
  assign bar_iy_dx  = bdx_r[0];
  assign bar_iz_dx  = bdx_r[1];
  assign bar2_iy_dx = bdx_r[2];
  assign bar2_iz_dx = bdx_r[3];
`else
  logic unused_bary_s;
  assign unused_bary_s = ^{bar_iy_in, bar_iz_in, bar2_iy_in, bar2_iz_in,
                           bar_iy_dy_in, bar_iz_dy_in, bar2_iy_dy_in, bar2_iz_dy_in,
                           bar_iy_dx_in, bar_iz_dx_in, bar2_iy_dx_in, bar2_iz_dx_in};

  assign bar_iy     = 22'sd0;
  assign bar_iz     = 22'sd0;
  assign bar2_iy    = 22'sd0;
  assign bar2_iz    = 22'sd0;
  assign bar_iy_dx  = 22'sd0;
  assign bar_iz_dx  = 22'sd0;
  assign bar2_iy_dx = 22'sd0;
  assign bar2_iz_dx = 22'sd0;
`endif

endmodule
